// File: rtl/uart_tx_if.sv
// CPU data-bus bundle for the UART transmitter.
// master: drives address, strobes and write data; samples read data.
// slave:  samples address, strobes and write data; returns combinational read data.
interface uart_tx_if;
  logic [31:0] addr;   // byte address
  logic        we;     // single-cycle write strobe
  logic        rd;     // single-cycle read strobe
  logic [31:0] wdata;  // write data, only [7:0] meaningful to the UART
  logic [31:0] rdata;  // combinational read data, 0 when unmapped

  modport master (output addr, output we, output rd, output wdata, input rdata);
  modport slave  (input addr, input we, input rd, input wdata, output rdata);
endinterface

// File: rtl/uart_tx.sv
// Purpose: memory-mapped UART transmitter, 8 data bits, 1 stop bit, LSB first,
//          optional even parity bit when UART_TX_PARITY_EN is defined (8E1).
// Latency: a TXD write reaches the line 2 clk edges later when idle; frames are
//          DIV cycles per bit, back-to-back frames have no idle gap.
// Backpressure: one holding byte; writes to TXD while it is full are dropped,
//          software polls STATUS.hold_full or waits for irq (done_flag).
// Ports: clk, rst_n (async active-low); bus (uart_tx_if.slave: addr, we, rd,
//        wdata, rdata); tx (serial line, idle high); irq (= done_flag).
// Register map: 0x40000018 TXD (write-only, reads 0);
//               0x40000020 STATUS {bit4 hold_full, bit3 done_flag, bit2 busy}.
module uart_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       irq
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  localparam logic [31:0] ADDR_TXD    = 32'h4000_0018;
  localparam logic [31:0] ADDR_STATUS = 32'h4000_0020;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    hold;
  logic          hold_full;
  logic          done_flag;
  logic          tx_q;

  logic wr_txd;
  logic rd_status;
  logic baud_end;
  logic stop_end;
  logic busy;
  logic load_shifter;
  logic unused_wdata;

  assign wr_txd    = bus.we && (bus.addr == ADDR_TXD);
  assign rd_status = bus.rd && (bus.addr == ADDR_STATUS);
  assign baud_end  = (baud_cnt == CNT_LAST);
  assign stop_end  = (state == S_STOP) && baud_end;
  assign busy      = (state != S_IDLE);
  // The shifter takes the held byte either from idle or straight out of STOP,
  // which is what makes back-to-back frames gapless.
  assign load_shifter = hold_full && ((state == S_IDLE) || stop_end);

  assign unused_wdata = ^bus.wdata[31:8];

  assign bus.rdata = (bus.addr == ADDR_STATUS)
                   ? {27'd0, hold_full, done_flag, busy, 2'b00}
                   : 32'd0;

  assign tx  = tx_q;
  assign irq = done_flag;

  // Holding register. A write only lands when hold is empty as seen this
  // cycle, so a write coinciding with the transfer is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= 8'd0;
      hold_full <= 1'b0;
    end else if (load_shifter) begin
      hold_full <= 1'b0;
    end else if (wr_txd && !hold_full) begin
      hold      <= bus.wdata[7:0];
      hold_full <= 1'b1;
    end
  end

  // done_flag: setting at end of STOP has priority over a STATUS read clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_flag <= 1'b0;
    end else if (stop_end) begin
      done_flag <= 1'b1;
    end else if (rd_status) begin
      done_flag <= 1'b0;
    end
  end

  // Shifter FSM. tx_q is loaded with the level of the state being entered,
  // so the line changes exactly on the state-entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (hold_full) begin
            shift <= hold;
            state <= S_START;
            tx_q  <= 1'b0;
          end
        end

        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= S_DATA;
            tx_q     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx_q  <= ^shift;
`else
              state <= S_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            tx_q     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (hold_full) begin
              shift <= hold;
              state <= S_START;
              tx_q  <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with DIV = 16. A line-level reference model predicts, for
// every sampled cycle, the tx level, busy, hold_full and done_flag from whole
// frames (start, data LSB first, optional parity, stop) held in a queue.
module tb_uart_tx;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam logic [31:0] TXD    = 32'h4000_0018;
  localparam logic [31:0] STATUS = 32'h4000_0020;
  localparam logic [31:0] UNMAP  = 32'h4000_0010;

  logic clk;
  logic rst_n;
  logic tx;
  logic irq;

  uart_tx_if bus_if ();

  uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .tx    (tx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic lvl;   // expected tx level
    logic busy;  // shifter expected non-idle
    logic last;  // final cycle of a frame's stop bit
  } ent_t;

  ent_t lineq[$];
  int   pend;     // samples left during which hold is expected full
  logic done_m;
  int   n_vec;
  int   n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_bit(input logic lvl, input logic is_stop);
    ent_t e;
    for (int c = 0; c < DIV; c++) begin
      e.lvl  = lvl;
      e.busy = 1'b1;
      e.last = is_stop && (c == DIV - 1);
      lineq.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    push_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) push_bit(b[i], 1'b0);
    if (NBITS == 11) push_bit(^b, 1'b0);
    push_bit(1'b1, 1'b1);
  endtask

  // One clock cycle: check outputs of the current state, apply this cycle's
  // bus inputs, check combinational read data, then advance the model.
  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    ent_t idle_e;
    logic hf_now;
    logic [31:0] exp_rd;
    @(negedge clk);
    idle_e = '{lvl: 1'b1, busy: 1'b0, last: 1'b0};
    if (lineq.size() > 0) e = lineq.pop_front();
    else e = idle_e;
    hf_now = (pend > 0);
    if (pend > 0) pend--;
    chk("tx", {31'd0, tx}, {31'd0, e.lvl});
    chk("irq", {31'd0, irq}, {31'd0, done_m});
    bus_if.addr  = a;
    bus_if.we    = w;
    bus_if.rd    = r;
    bus_if.wdata = d;
    #1;
    exp_rd = (a == STATUS) ? {27'd0, hf_now, done_m, e.busy, 2'b00} : 32'd0;
    chk("rdata", bus_if.rdata, exp_rd);
    if (w && a == TXD && !hf_now) begin
      if (lineq.size() == 0) lineq.push_back(idle_e);
      pend = lineq.size();
      push_frame(d[7:0]);
    end
    if (e.last) done_m = 1'b1;
    else if (r && a == STATUS) done_m = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] b);
    step(1'b1, 1'b0, a, {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), b});
  endtask

  task automatic rdr(input logic [31:0] a);
    step(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    lineq.delete();
    pend   = 0;
    done_m = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    pend = 0;
    done_m = 1'b0;
    rst_n = 1'b0;
    bus_if.addr = 32'd0;
    bus_if.we = 1'b0;
    bus_if.rd = 1'b0;
    bus_if.wdata = 32'd0;
    do_reset();
    idle(3);
    rdr(STATUS);

    // Single 0x55 frame, then STATUS shows only done_flag.
    wr(TXD, 8'h55);
    idle(NBITS * DIV + 10);
    // Read-to-clear: first read 0x08, irq drops, second read 0x00.
    rdr(STATUS);
    idle(1);
    rdr(STATUS);

    // Two contiguous frames; 0xFF arrives while hold is full and is dropped.
    wr(TXD, 8'hA3);
    idle(20);
    wr(TXD, 8'h3C);
    idle(5);
    wr(TXD, 8'hFF);
    idle(2 * NBITS * DIV + 20);
    rdr(STATUS);

    // Write in the same cycle as the hold-to-shifter transfer is dropped.
    wr(TXD, 8'h96);
    wr(TXD, 8'h11);
    idle(NBITS * DIV - 1);
    // STATUS read on the final STOP cycle: the set wins.
    rdr(STATUS);
    idle(3);
    rdr(STATUS);

    // Unmapped and write-only addresses read 0; unmapped write sends nothing.
    rdr(UNMAP);
    rdr(TXD);
    wr(UNMAP, 8'h12);
    idle(50);

    // Reset mid-frame at cycle 50 of a 0x00 frame.
    wr(TXD, 8'h00);
    idle(51);
    do_reset();
    idle(2);
    rdr(STATUS);
    idle(NBITS * DIV);
    rdr(STATUS);

    // Parity-sensitive byte.
    wr(TXD, 8'h07);
    idle(NBITS * DIV + 4);
    rdr(STATUS);

    // Randomized bus traffic.
    for (int i = 0; i < 600; i++) begin
      int op;
      op = $urandom_range(0, 11);
      if (op <= 5) idle(1);
      else if (op <= 7) wr(TXD, 8'($urandom_range(0, 255)));
      else if (op == 8) rdr(STATUS);
      else if (op == 9) wr(UNMAP, 8'($urandom_range(0, 255)));
      else if (op == 10) rdr(UNMAP);
      else idle($urandom_range(1, 60));
    end
    idle(2 * NBITS * DIV + 10);
    rdr(STATUS);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD, integer division, DIV >= 2.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 addr  input  32  CPU data-bus byte address.
REQ-006 we  input  1  CPU bus write strobe, single-cycle.
REQ-007 rd  input  1  CPU bus read strobe, single-cycle.
REQ-008 wdata  input  32  CPU write data; only bits [7:0] are used.
REQ-009 rdata  output  32  combinational read data for the addressed register; 0 when addr is unmapped.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 irq  output  1  high while done_flag = 1.

Function
REQ-012 Register map: 0x40000018 TXD (write-only, reads 0); 0x40000020 STATUS (read-only); all other addresses ignored.
REQ-013 STATUS: bit2 = busy (shifter not IDLE), bit3 = done_flag, bit4 = hold_full, all other bits 0.
REQ-014 Buffering: 1-byte holding register plus shift register.
REQ-015 A write to TXD with hold_full = 0 latches wdata[7:0] and sets hold_full at the next edge.
REQ-016 A write to TXD with hold_full = 1 is dropped and has no side effect.
REQ-017 Shifter FSM states: IDLE, START, DATA, [PARITY], STOP.
REQ-018 IDLE with hold_full = 1: on the next edge, move hold into the shifter, clear hold_full, and enter START.
REQ-019 Each non-IDLE state lasts exactly DIV cycles, timed by a baud counter that restarts at 0 on every state entry.
REQ-020 tx levels: IDLE = 1; START = 0; DATA = bit[i], LSB first, i = 0..7; STOP = 1.
REQ-021 Transitions: START -> DATA; DATA -> DATA until i = 7, then -> PARITY or STOP; STOP -> IDLE.
REQ-022 tx is driven from a register, so it is glitch-free.
REQ-023 At the end of STOP: set done_flag; if hold_full = 1, go directly to START with the new byte, with no idle bit between frames.
REQ-024 Back-to-back frame length is 10*DIV cycles, or 11*DIV cycles with parity.
REQ-025 A write accepted while the shifter is busy fills hold and does not disturb the frame in progress.
REQ-026 A rd strobe to STATUS clears done_flag at the next edge; rdata in that cycle still shows done_flag = 1.
REQ-027 If a STOP end and a STATUS read occur in the same cycle, the set wins: done_flag = 1.
REQ-028 If a TXD write and the hold-to-shifter transfer occur in the same cycle, the transfer takes the old byte and the write is dropped, because hold_full was 1.

Reset
REQ-029 rst_n low asynchronously forces: tx = 1, FSM = IDLE, baud counter = 0, bit index = 0, hold_full = 0, done_flag = 0, irq = 0.
REQ-030 Reset asserted mid-frame aborts the frame immediately and drives tx high; no partial frame resumes after release.
REQ-031 Operation restarts on the first clk edge after rst_n rises.

Configuration
REQ-032 Macro UART_TX_PARITY_EN defined: PARITY state is inserted after DATA bit 7, lasting DIV cycles, with tx = XOR of the 8 data bits (even parity).
REQ-033 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic are absent and the frame is 8N1.

Verification
REQ-034 CLK_FREQ=16, BAUD=1 (DIV=16): write 0x55 to 0x40000018 -> tx low for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles; STATUS = 0x08 afterwards.
REQ-035 Write 0xA3, then 0x3C while busy, then 0xFF while hold_full = 1 -> exactly two frames, 0xA3 then 0x3C, contiguous (320 cycles total); 0xFF never appears on tx.
REQ-036 After a frame, read 0x40000020 -> rdata = 0x08 with irq = 1; next cycle irq = 0; a second read returns 0x00.
REQ-037 Pulse rst_n low at cycle 50 of a 0x00 frame -> tx = 1 within the same cycle; STATUS = 0 after release; no done_flag is set.
REQ-038 With UART_TX_PARITY_EN defined, write 0x07 -> parity bit = 1 and the frame lasts 176 cycles; with the macro undefined the frame lasts 160 cycles.
REQ-039 Read an unmapped address (0x40000010) and read 0x40000018 -> rdata = 0; write 0x12 to 0x40000010 -> no frame on tx.
